ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 122 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes; sign fix-up on entry to DONE.
module ex_muldiv_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [WORD_WIDTH-1:0] opA_i,
    input  logic [WORD_WIDTH-1:0] opB_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] result_o
);

    localparam int W = WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           op_q;
    logic                 sign_a, sign_b;
    logic [W-1:0]         opnd_b;
    logic [2*W-1:0]       acc, acc_next;
    logic [W-1:0]         result_q;

    logic         accept, a_signed, b_signed, sa, sb, div_zero, overflow, special, last_step;
    logic [W-1:0] mag_a, mag_b, special_res, final_res, quo, rem;
    logic [W:0]   mul_sum, div_diff;
    logic [2*W-1:0] prod;

    // Operand decode at acceptance
    always_comb begin
        accept      = (state == IDLE) && start_i && !flush_i;
        a_signed    = (op_i != 3'b011) && (op_i != 3'b101) && (op_i != 3'b111);
        b_signed    = a_signed && (op_i != 3'b010);
        sa          = a_signed && opA_i[W-1];
        sb          = b_signed && opB_i[W-1];
        mag_a       = sa ? -opA_i : opA_i;
        mag_b       = sb ? -opB_i : opB_i;
        div_zero    = op_i[2] && (opB_i == '0);
        overflow    = op_i[2] && !op_i[0] && (opA_i == {1'b1, {(W-1){1'b0}}}) && (opB_i == '1);
        special     = div_zero || overflow;
        if (div_zero) special_res = op_i[1] ? opA_i : '1;
        else          special_res = op_i[1] ? '0 : opA_i;
    end

    // One radix-2 step; the low half holds the multiplier or the dividend/quotient bits
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_b} : '0);
        div_diff = acc[2*W-1:W-1] - {1'b0, opnd_b};
        if (!op_q[2])         acc_next = {mul_sum, acc[W-1:1]};
        else if (!div_diff[W]) acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        else                  acc_next = {acc[2*W-2:0], 1'b0};
    end

    always_comb begin
        last_step = (cnt == CNT_WIDTH'(1));
        prod      = (sign_a ^ sign_b) ? -acc_next : acc_next;
        quo       = (sign_a ^ sign_b) ? -acc_next[W-1:0] : acc_next[W-1:0];
        rem       = sign_a ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
        if (!op_q[2])    final_res = (op_q == 3'b000) ? prod[W-1:0] : prod[2*W-1:W];
        else if (op_q[1]) final_res = rem;
        else             final_res = quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (flush_i)        state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_o = rst_n && (accept || (state == CALC));
        busy_o  = (state != IDLE);
        done_o  = (state == DONE) && !flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            opnd_b   <= '0;
            acc      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= op_i;
            sign_a <= sa;
            sign_b <= sb;
            opnd_b <= mag_b;
            acc    <= {{W{1'b0}}, mag_a};
            cnt    <= CNT_WIDTH'(W);
            if (special) result_q <= special_res;
        end else if (state == CALC) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (last_step && !flush_i) result_q <= final_res;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, flush/reset sequences, random ops vs. arithmetic model.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         flush_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] opA_i = '0;
    logic [W-1:0] opB_i = '0;
    logic         stall_o, busy_o, done_o;
    logic [W-1:0] result_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WORD_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .opA_i    (opA_i),
        .opB_i    (opB_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from 64-bit arithmetic
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, ub, q;
        logic [63:0]        ua, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return '1;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at the next negedge; returns at the negedge where done_o was seen.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input string name);
        bit sp;
        int lat;
        int stall_bad;
        bit got;
        sp = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        lat = sp ? 1 : W + 1;
        stall_bad = 0;
        got = 0;
        @(negedge clk);
        check({name, " idle"}, {62'h0, busy_o, done_o}, 64'h0);
        start_i = 1'b1; op_i = op; opA_i = a; opB_i = b; flush_i = 1'b0;
        #1 check({name, " accept stall"}, {63'h0, stall_o}, 64'h1);
        for (int n = 1; n <= 60 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start_i = 1'b0;
                opA_i = $urandom;
                opB_i = $urandom;
            end
            if (done_o) begin
                got = 1;
                check({name, " latency"}, 64'(n), 64'(lat));
                check({name, " result"}, {32'h0, result_o}, {32'h0, exp});
                check({name, " done stall"}, {63'h0, stall_o}, 64'h0);
            end else if (!stall_o || !busy_o) begin
                stall_bad++;
            end
        end
        if (!got) check({name, " timeout"}, 64'h0, 64'h1);
        check({name, " stall/busy while calc"}, 64'(stall_bad), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] last_res;
        int           done_seen;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14});
        vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2});
        vecs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'd5,          32'd0,         32'd5});
        vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000});

        // Reset state, with start_i asserted to confirm stall_o stays low
        start_i = 1'b1;
        #12;
        check("reset outputs", {29'h0, stall_o, busy_o, done_o, result_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_i = 1'b0;

        // Directed vectors, issued back to back
        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        last_res = vecs[vecs.size()-1].exp;

        // Flush during CALC: no done, result held, next op works
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; opA_i = 32'd1000; opB_i = 32'd3;
        done_seen = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_o) done_seen++;
            if (n == 10) flush_i = 1'b1;
            if (n == 11) begin
                check("flush busy", {63'h0, busy_o}, 64'h0);
                flush_i = 1'b0;
            end
        end
        check("flush no done", 64'(done_seen), 64'h0);
        check("flush result held", {32'h0, result_o}, {32'h0, last_res});
        run_op(3'd0, 32'd3, 32'd4, 32'd12, "mul after flush");

        // Asynchronous reset mid-multiply
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; opA_i = 32'h1234; opB_i = 32'h5678;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #1 start_i = 1'b1;
        rst_n = 1'b0;
        #1 check("async reset outputs", {29'h0, stall_o, busy_o, done_o, result_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_i = 1'b0;
        run_op(3'd5, 32'd9, 32'd3, 32'd3, "divu after reset");

        // Random operations against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, ref_model(rop, ra, rb), $sformatf("rand%0d op%0d %h %h", k, rop, ra, rb));
        end

        @(negedge clk);
        check("final idle", {62'h0, busy_o, done_o}, 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
